// File: rtl/disp_wr_arbiter_pkg.sv
// Shared constants and FSM encoding for the display write arbiter.
// The digit buffer geometry matches an 8-digit, 4-bit-per-digit display driver.
package disp_pkg;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 8;
    localparam int ADDR_W     = 3;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    // One-hot grant seen by the requesters for a given arbiter state.
    function automatic logic [1:0] state_to_gnt(input state_t s);
        logic [1:0] g;
        g = 2'b00;
        case (s)
            GRANT0:  g = 2'b01;
            GRANT1:  g = 2'b10;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/disp_wr_arbiter_if.sv
// Bus between the two digit-writing requesters and the display write arbiter.
// The master side drives requests, the slave side returns grant and buffer state.
interface disp_wr_arbiter_if;
    import disp_pkg::*;

    logic [1:0]                      req;
    logic [ADDR_W-1:0]               addr0;
    logic [ADDR_W-1:0]               addr1;
    logic [DIGIT_W-1:0]              data0;
    logic [DIGIT_W-1:0]              data1;
    logic [1:0]                      gnt;
    logic [NUM_DIGITS*DIGIT_W-1:0]   digits;
    logic                            busy;

    modport master (
        output req, addr0, addr1, data0, data1,
        input  gnt, digits, busy
    );

    modport slave (
        input  req, addr0, addr1, data0, data1,
        output gnt, digits, busy
    );

endinterface

// File: rtl/disp_wr_arbiter_burst_cnt.sv
// Counts consecutive granted writes for the current owner of the display bus.
// Saturates at MAX_BURST and clears whenever the arbiter changes state.
module burst_cnt
    import disp_pkg::*;
#(
    parameter int MAX_BURST = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] SAT = CNT_W'(MAX_BURST);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && (count != SAT)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/disp_wr_arbiter.sv
// Two-requester write arbiter for an 8-digit display buffer with fair
// tie-breaking and a burst limit that only bites while the other side waits.
module disp_wr_arbiter
    import disp_pkg::*;
#(
    parameter int MAX_BURST = 8
) (
    input  logic               clk,
    input  logic               reset,
    disp_wr_arbiter_if.slave   bus
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_BURST - 1);

    state_t                                  state;
    logic [1:0]                              gnt_q;
    logic                                    busy_q;
    logic                                    last_served;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]      digit_buf;
    logic [CNT_W-1:0]                        burst;

    logic                                    own_req;
    logic                                    other_req;
    logic                                    at_limit;
    logic                                    wr_en;
    logic                                    leave;
    logic                                    enter;
    logic                                    cnt_clr;
    logic [ADDR_W-1:0]                       wr_addr;
    logic [DIGIT_W-1:0]                      wr_data;

    always_comb begin
        own_req   = 1'b0;
        other_req = 1'b0;
        wr_addr   = bus.addr0;
        wr_data   = bus.data0;
        case (state)
            GRANT0: begin
                own_req   = bus.req[0];
                other_req = bus.req[1];
            end
            GRANT1: begin
                own_req   = bus.req[1];
                other_req = bus.req[0];
                wr_addr   = bus.addr1;
                wr_data   = bus.data1;
            end
            default: begin
                own_req   = 1'b0;
                other_req = 1'b0;
            end
        endcase
    end

    // A saturated counter still counts as "at limit" so a late-arriving
    // requester cannot be starved by a long solo burst.
    assign at_limit = (burst >= LIMIT);
    assign wr_en    = |(bus.req & gnt_q);
    assign leave    = (state != IDLE) && (!own_req || (other_req && at_limit));
    assign enter    = (state == IDLE) && (|bus.req);
    assign cnt_clr  = leave || enter;

    burst_cnt #(
        .MAX_BURST (MAX_BURST)
    ) u_burst_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (wr_en),
        .clr   (cnt_clr),
        .count (burst)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            gnt_q       <= 2'b00;
            busy_q      <= 1'b0;
            last_served <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req == 2'b01 || (bus.req == 2'b11 && last_served)) begin
                        state  <= GRANT0;
                        gnt_q  <= state_to_gnt(GRANT0);
                        busy_q <= 1'b1;
                    end else if (bus.req != 2'b00) begin
                        state  <= GRANT1;
                        gnt_q  <= state_to_gnt(GRANT1);
                        busy_q <= 1'b1;
                    end
                end
                GRANT0: begin
                    last_served <= 1'b0;
                    if (leave) begin
                        if (other_req) begin
                            state  <= GRANT1;
                            gnt_q  <= state_to_gnt(GRANT1);
                            busy_q <= 1'b1;
                        end else begin
                            state  <= IDLE;
                            gnt_q  <= state_to_gnt(IDLE);
                            busy_q <= 1'b0;
                        end
                    end
                end
                GRANT1: begin
                    last_served <= 1'b1;
                    if (leave) begin
                        if (other_req) begin
                            state  <= GRANT0;
                            gnt_q  <= state_to_gnt(GRANT0);
                            busy_q <= 1'b1;
                        end else begin
                            state  <= IDLE;
                            gnt_q  <= state_to_gnt(IDLE);
                            busy_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    gnt_q  <= 2'b00;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Reset wins over a write landing on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            digit_buf <= '0;
        end else if (wr_en) begin
            digit_buf[wr_addr] <= wr_data;
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.busy   = busy_q;
    assign bus.digits = digit_buf;

endmodule
